// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and defaults for the elevator call scheduler: FSM states, direction encoding, sizing helper.
package elev_pkg;

    localparam int DEF_NUM_FLOORS = 16;
    localparam int DEF_FLOOR_W    = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DWELL     = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Panel/car-side bundle of the scheduler: master drives calls and car position, slave returns commands.
interface elevator_call_scheduler_if
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    car_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic                  Up;
    logic                  Down;
    logic                  door;
    logic                  busy;

    modport master (
        output call_req, car_floor,
        input  pending, target_floor, target_valid, Up, Down, door, busy
    );

    modport slave (
        input  call_req, car_floor,
        output pending, target_floor, target_valid, Up, Down, door, busy
    );
endinterface

// File: rtl/elevator_call_scheduler_picker.sv
// Combinational SCAN picker: nearest pending floor above and below the car, and whether the car's floor is called.
module elev_scan_picker
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic [FLOOR_W-1:0]    above,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    below,
    output logic                  below_found,
    output logic                  here
);
    logic floor_ok;

    // A car position outside the building yields no candidates at all.
    assign floor_ok = int'(car_floor) < NUM_FLOORS;

    always_comb begin
        above       = '0;
        above_found = 1'b0;
        below       = '0;
        below_found = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (floor_ok && pending[i] && (i > int'(car_floor))) begin
                above       = FLOOR_W'(i);
                above_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_ok && pending[i] && (i < int'(car_floor))) begin
                below       = FLOOR_W'(i);
                below_found = 1'b1;
            end
        end
    end

    assign here = floor_ok && pending[car_floor];

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator call scheduler: pending-call register, direction FSM, door dwell timer.
// Optional lobby return after idle timeout when ELEV_LOBBY_RETURN_EN is defined.
module elevator_call_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int DWELL_CYCLES  = 8,
    parameter int LOBBY_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    elevator_call_scheduler_if.slave bus
);
    localparam int              DW_W       = cnt_width(DWELL_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 1 || LOBBY_TIMEOUT < 1 || (2 ** FLOOR_W) < NUM_FLOORS) begin : g_bad_params
        $error("elevator_call_scheduler: illegal parameter combination");
    end

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] pending_q, pending_nxt, clear_mask;
    logic [FLOOR_W-1:0]    target_q, target_nxt;
    logic                  target_valid_q, up_q, down_q, door_q;
    logic                  last_dir, last_dir_nxt;
    logic [DW_W-1:0]       dwell_cnt, dwell_nxt;
    logic                  lobby_call;
    logic                  floor_ok, repress;

    logic [FLOOR_W-1:0]    above, below;
    logic                  above_found, below_found, here;

    elev_scan_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pending     (pending_q),
        .car_floor   (bus.car_floor),
        .above       (above),
        .above_found (above_found),
        .below       (below),
        .below_found (below_found),
        .here        (here)
    );

    assign floor_ok = int'(bus.car_floor) < NUM_FLOORS;
    // A fresh press at the floor being served extends the open door instead of queueing.
    assign repress  = (state == DWELL) && floor_ok && bus.call_req[bus.car_floor];

    always_comb begin
        state_nxt    = state;
        target_nxt   = target_q;
        last_dir_nxt = last_dir;
        dwell_nxt    = dwell_cnt;
        clear_mask   = '0;

        unique case (state)
            IDLE: begin
                if (here)             state_nxt = DWELL;
                else if (above_found) state_nxt = MOVE_UP;
                else if (below_found) state_nxt = MOVE_DOWN;
            end
            MOVE_UP: begin
                if (here)             state_nxt = DWELL;
                else if (above_found) state_nxt = MOVE_UP;
                else if (below_found) state_nxt = MOVE_DOWN;
                else                  state_nxt = IDLE;
            end
            MOVE_DOWN: begin
                if (here)             state_nxt = DWELL;
                else if (below_found) state_nxt = MOVE_DOWN;
                else if (above_found) state_nxt = MOVE_UP;
                else                  state_nxt = IDLE;
            end
            DWELL: begin
                if (repress)                dwell_nxt = DWELL_LOAD;
                else if (dwell_cnt != '0)   dwell_nxt = dwell_cnt - 1'b1;
                else if (last_dir == DIR_UP)
                    state_nxt = above_found ? MOVE_UP : (below_found ? MOVE_DOWN : IDLE);
                else
                    state_nxt = below_found ? MOVE_DOWN : (above_found ? MOVE_UP : IDLE);
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == DWELL && state != DWELL) dwell_nxt = DWELL_LOAD;

        if (state_nxt == MOVE_UP) begin
            target_nxt   = above;
            last_dir_nxt = DIR_UP;
        end else if (state_nxt == MOVE_DOWN) begin
            target_nxt   = below;
            last_dir_nxt = DIR_DOWN;
        end

        // The floor being served never holds a pending bit, even if pressed in the same cycle.
        if (floor_ok && (state == DWELL || state_nxt == DWELL)) clear_mask[bus.car_floor] = 1'b1;
    end

    assign pending_nxt = (pending_q | bus.call_req | {{(NUM_FLOORS-1){1'b0}}, lobby_call}) & ~clear_mask;

`ifdef ELEV_LOBBY_RETURN_EN
    localparam int IW = cnt_width(LOBBY_TIMEOUT);

    logic [IW-1:0] idle_cnt;
    logic          idle_qual;

    assign idle_qual  = (state == IDLE) && (bus.car_floor != '0) && (pending_q == '0) && (bus.call_req == '0);
    assign lobby_call = idle_qual && (idle_cnt == IW'(LOBBY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)            idle_cnt <= '0;
        else if (!idle_qual)  idle_cnt <= '0;
        else if (lobby_call)  idle_cnt <= '0;
        else                  idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign lobby_call = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pending_q      <= '0;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            up_q           <= 1'b0;
            down_q         <= 1'b0;
            door_q         <= 1'b1;
            dwell_cnt      <= '0;
            last_dir       <= DIR_UP;
        end else begin
            state          <= state_nxt;
            pending_q      <= pending_nxt;
            target_q       <= target_nxt;
            target_valid_q <= (state_nxt == MOVE_UP) || (state_nxt == MOVE_DOWN);
            up_q           <= (state_nxt == MOVE_UP);
            down_q         <= (state_nxt == MOVE_DOWN);
            door_q         <= (state_nxt == IDLE) || (state_nxt == DWELL);
            dwell_cnt      <= dwell_nxt;
            last_dir       <= last_dir_nxt;
        end
    end

    assign bus.pending      = pending_q;
    assign bus.target_floor = target_q;
    assign bus.target_valid = target_valid_q;
    assign bus.Up           = up_q;
    assign bus.Down         = down_q;
    assign bus.door         = door_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus randomized calls/car motion against a behavioural model.
module tb_elevator_call_scheduler;
    localparam int N     = 16;
    localparam int FW    = 4;
    localparam int DWELL = 8;
    localparam int LOBBY = 64;

    logic clk;
    logic reset;

    elevator_call_scheduler_if #(.NUM_FLOORS(N), .FLOOR_W(FW)) bus ();

    elevator_call_scheduler #(
        .NUM_FLOORS    (N),
        .FLOOR_W       (FW),
        .DWELL_CYCLES  (DWELL),
        .LOBBY_TIMEOUT (LOBBY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;
    bit down_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: car is either travelling (m_dir = +1/-1), parked with the door open
    // for m_left more cycles, or parked idle.
    logic [N-1:0] m_pend   = '0;
    int           m_dir    = 0;
    bit           m_dwell  = 0;
    int           m_left   = 0;
    int           m_last   = 1;
    int           m_target = 0;
`ifdef ELEV_LOBBY_RETURN_EN
    int           m_idle_run = 0;
`endif

    task automatic head(input int pref, input int above, input int below);
        if (pref > 0 && above >= 0) begin
            m_dir = 1;  m_target = above; m_last = 1;
        end else if (below >= 0) begin
            m_dir = -1; m_target = below; m_last = -1;
        end else if (above >= 0) begin
            m_dir = 1;  m_target = above; m_last = 1;
        end else begin
            m_dir = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] old, nxt;
        int cf, above, below;
        bit here, idle;
        if (reset) begin
            m_pend = '0; m_dir = 0; m_dwell = 0; m_left = 0; m_last = 1;
`ifdef ELEV_LOBBY_RETURN_EN
            m_idle_run = 0;
`endif
            return;
        end
        old  = m_pend;
        cf   = int'(bus.car_floor);
        idle = !m_dwell && m_dir == 0;
        above = -1;
        below = -1;
        for (int d = 1; d < N; d++) begin
            if (above < 0 && cf + d < N && old[FW'(cf + d)]) above = cf + d;
            if (below < 0 && cf - d >= 0 && old[FW'(cf - d)]) below = cf - d;
        end
        here = (cf < N) && old[FW'(cf)];
        nxt  = old | bus.call_req;
`ifdef ELEV_LOBBY_RETURN_EN
        if (idle && cf != 0 && old == '0 && bus.call_req == '0) begin
            m_idle_run++;
            if (m_idle_run == LOBBY) begin
                nxt[0] = 1'b1;
                m_idle_run = 0;
            end
        end else begin
            m_idle_run = 0;
        end
`endif
        if (m_dwell) begin
            if (cf < N) nxt[FW'(cf)] = 1'b0;
            if (cf < N && bus.call_req[FW'(cf)]) m_left = DWELL;
            else if (m_left > 1)                 m_left--;
            else begin
                m_dwell = 0;
                head(m_last, above, below);
            end
        end else if (here) begin
            m_dwell = 1; m_left = DWELL; m_dir = 0;
            nxt[FW'(cf)] = 1'b0;
        end else begin
            head(idle ? 1 : m_dir, above, below);
        end
        m_pend = nxt;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (bus.Down) down_seen = 1;
        if (cmp_en) begin
            check("m_pending", 32'(bus.pending), 32'(m_pend));
            check("m_up",      32'(bus.Up),   32'(m_dir == 1));
            check("m_down",    32'(bus.Down), 32'(m_dir == -1));
            check("m_door",    32'(bus.door), 32'(m_dir == 0));
            check("m_tvalid",  32'(bus.target_valid), 32'(m_dir != 0));
            check("m_busy",    32'(bus.busy), 32'(m_dir != 0 || m_dwell));
            if (m_dir != 0) check("m_target", 32'(bus.target_floor), m_target);
        end
    end

    // which: 0 = Up, 1 = Down, 2 = idle
    task automatic wait_cond(input string name, input int which, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = bus.Up;
                1:       ok = bus.Down;
                default: ok = !bus.busy;
            endcase
        end
        check(name, 32'(ok), 1);
    endtask

    task automatic pulse_call(input logic [N-1:0] calls);
        bus.call_req = calls;
        @(negedge clk);
        bus.call_req = '0;
    endtask

    int cnt;
    int r;

    initial begin
        reset        = 1'b1;
        bus.call_req = '1;
        bus.car_floor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_door",    32'(bus.door), 1);
        check("rst_up",      32'(bus.Up), 0);
        check("rst_down",    32'(bus.Down), 0);
        check("rst_tvalid",  32'(bus.target_valid), 0);
        bus.call_req = '0;
        reset  = 1'b0;
        cmp_en = 1;
        @(negedge clk);
        check("rel_busy", 32'(bus.busy), 0);

        // Single call above an idle car at floor 0.
        bus.call_req = 16'h0020;
        @(negedge clk);
        bus.call_req = '0;
        check("t2_pending", 32'(bus.pending), 32'h20);
        check("t2_up_early", 32'(bus.Up), 0);
        @(negedge clk);
        check("t2_up",     32'(bus.Up), 1);
        check("t2_target", 32'(bus.target_floor), 5);
        check("t2_door",   32'(bus.door), 0);
        bus.car_floor = 4'd5;
        @(negedge clk);
        check("t2_dwell_door", 32'(bus.door), 1);
        check("t2_dwell_pend", 32'(bus.pending), 0);
        cnt = 0;
        for (int i = 0; i < 30 && bus.busy; i++) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_dwell_len", cnt, 8);

        // En-route call between car and target.
        bus.car_floor = 4'd3;
        down_seen = 0;
        pulse_call(16'h0200);
        @(negedge clk);
        check("t3_target9", 32'(bus.target_floor), 9);
        bus.car_floor = 4'd4;
        pulse_call(16'h0040);
        @(negedge clk);
        check("t3_target6", 32'(bus.target_floor), 6);
        bus.car_floor = 4'd5;
        @(negedge clk);
        bus.car_floor = 4'd6;
        @(negedge clk);
        check("t3_dwell6", 32'(bus.door), 1);
        wait_cond("t3_resume_up", 0, 20);
        check("t3_target_again9", 32'(bus.target_floor), 9);
        bus.car_floor = 4'd9;
        wait_cond("t3_idle", 2, 30);
        check("t3_no_down", 32'(down_seen), 0);

        // Direction memory: after a downward trip, dwell exit prefers going down.
        pulse_call(16'h0010);
        wait_cond("t4_down_to4", 1, 10);
        check("t4_target4", 32'(bus.target_floor), 4);
        bus.car_floor = 4'd4;
        @(negedge clk);
        check("t4_dwell4", 32'(bus.door), 1);
        pulse_call(16'h0084);
        wait_cond("t4_down_to2", 1, 20);
        check("t4_target2", 32'(bus.target_floor), 2);
        check("t4_not_up",  32'(bus.Up), 0);
        bus.car_floor = 4'd2;
        wait_cond("t4_up_to7", 0, 20);
        check("t4_target7", 32'(bus.target_floor), 7);
        bus.car_floor = 4'd7;
        wait_cond("t4_idle", 2, 30);

        // Re-press during dwell restarts the door timer.
        pulse_call(16'h0010);
        wait_cond("t5_down", 1, 10);
        bus.car_floor = 4'd4;
        @(negedge clk);
        check("t5_dwell", 32'(bus.door), 1);
        repeat (4) @(negedge clk);
        bus.call_req = 16'h0010;
        @(negedge clk);
        bus.call_req = '0;
        check("t5_pend4", 32'(bus.pending[4]), 0);
        cnt = 0;
        for (int i = 0; i < 30 && bus.busy; i++) begin
            cnt++;
            @(negedge clk);
        end
        check("t5_dwell_len", cnt, 8);

        // Long idle away from the lobby.
        bus.car_floor = 4'd6;
`ifdef ELEV_LOBBY_RETURN_EN
        wait_cond("t6_lobby_down", 1, LOBBY + 10);
        check("t6_target0", 32'(bus.target_floor), 0);
        check("t6_pend0",   32'(bus.pending[0]), 1);
        bus.car_floor = 4'd0;
        wait_cond("t6_idle", 2, 30);
`else
        repeat (LOBBY + 10) @(negedge clk);
        check("t6_stay_idle", 32'(bus.busy), 0);
        check("t6_no_pend",   32'(bus.pending), 0);
`endif

        // Randomized calls with a car that follows the commands; includes a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = (i >= 1500 && i < 1502);
            r = $urandom_range(0, 15);
            if (r < 2)       bus.call_req = 16'(1 << $urandom_range(0, 15));
            else if (r == 2) bus.call_req = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
            else             bus.call_req = '0;
            if ($urandom_range(0, 2) == 0) begin
                if (bus.Up && bus.car_floor != 4'd15)       bus.car_floor = bus.car_floor + 4'd1;
                else if (bus.Down && bus.car_floor != 4'd0) bus.car_floor = bus.car_floor - 4'd1;
            end
        end
        bus.call_req = '0;
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
